load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Pipeline-side initiator for the word-wide data memory in the RISC-V core. It accepts one load/store request from EX (LB/LH/LW/LBU/LHU/SB/SH/SW) and converts the byte address into word-aligned memory accesses with byte enables. A misaligned access that crosses a word boundary is split into two accesses. Load data is reassembled, sign- or zero-extended, and returned with the write-back tag. It stalls EX while busy.

Parameters:
ADDR_W, 11, byte-address width on both sides; the word index is ADDR_W-2 bits.
DATA_W, 32, data width; only 32 is supported.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request present from EX
ready_o  out  1  unit idle and accepting a request; EX stalls when low
is_store_i  in  1  1 = store, 0 = load
funct3_i  in  3  RISC-V funct3 (size/sign)
addr_i  in  ADDR_W  byte address
wdata_i  in  32  store data, right-justified
wbAddr_i  in  5  destination register tag
wbEnable_i  in  1  write-back enable tag
flush_i  in  1  synchronous abort of the in-flight request
mem_en_o  out  1  memory access strobe
wr_en_o  out  1  write strobe, valid with mem_en_o
addr_o  out  ADDR_W  word-aligned byte address, addr_o[1:0] = 0
byte_en_o  out  4  lane enables
data_o  out  32  lane-positioned write data
rdata_i  in  32  memory read data, valid the cycle after a read access
result_o  out  32  extended load data; 0 for stores
result_valid_o  out  1  one-cycle completion pulse
err_o  out  1  illegal funct3, valid with result_valid_o
wbAddr_o  out  5  tag returned with the result
wbEnable_o  out  1  tag returned with the result; forced 0 on err

Behaviour:
- Reset: the state goes to IDLE. Every output is 0 except ready_o, which is 1. The latched request is cleared and any in-flight access is dropped.
- Size n: funct3[1:0] = 00 gives 1 byte, 01 gives 2, 10 gives 4. funct3 of x11, 110 or 111 is illegal. For stores, funct3[2] = 1 is also illegal.
- Offset and split: o = addr[1:0]. split = (o + n > 4).
- Access 0: word address addr[ADDR_W-1:2]. lanes0 = (((1<<n)-1) << o)[3:0].
- Access 1: word address addr[ADDR_W-1:2] + 1, wrapping modulo 2^(ADDR_W-2). lanes1 = ((1<<n)-1) >> (4-o).
- Store data: S = {32'b0, wdata_i} << 8*o. Access 0 drives S[31:0], access 1 drives S[63:32]. Lanes that are not enabled carry 0.
- Load data: L = ({rdata1, rdata0} >> 8*o), keeping the low n bytes. It is sign-extended when funct3[2] = 0 and zero-extended when funct3[2] = 1. rdata1 is taken as 0 when there is no split.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
  - IDLE: ready_o = 1. When req_valid_i is high, all inputs are latched. Next state is RESP with err set if funct3 is illegal, otherwise ISSUE0.
  - ISSUE0: drive access 0. Next state is ISSUE1 if split, else WAIT for a load, else RESP for a store.
  - ISSUE1: capture rdata_i as rdata0 (loads) and drive access 1. Next state is WAIT for a load, RESP for a store.
  - WAIT: capture the final rdata_i (rdata0 if unsplit, rdata1 if split). mem_en_o = 0. Next state is RESP.
  - RESP: result_valid_o = 1 with result_o, err_o and the tags. Next state is IDLE.
- Memory outputs are decoded only from the state register and latched fields. There is no combinational path from the req inputs to the mem outputs.
- Latency from the accept cycle T to the result_valid_o pulse:
  - unsplit load: T+3
  - split load: T+4
  - unsplit store: T+2
  - split store: T+3
  - illegal request: T+1, with no memory access
- ready_o is high only in IDLE, so a new request is accepted no earlier than the cycle after RESP. req_valid_i is ignored while ready_o = 0.
- flush_i: any non-IDLE state goes to IDLE next cycle and no RESP pulse is produced. An access driven in the same cycle as flush_i still occurs, so a committed write is not recalled. flush_i in IDLE blocks acceptance in that cycle.
- Outside ISSUE0/ISSUE1, mem_en_o, wr_en_o, byte_en_o and data_o are 0. result_o and the tags are held at 0 outside RESP.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum lsu_state_t
  - a size-decode function returning n and a legal flag
- Sub-module lsu_lane_align (combinational): takes o, n and wdata, and produces lanes0, lanes1 and S[63:0]. It also provides the load extract/extend function. The top module keeps the FSM and registers.

Test Plan:
1. LW at addr 0x010, memory word 0x010 = 0xDEADBEEF, tag 5/1 → one read at addr_o 0x010 with byte_en 1111; at T+3 result_o 0xDEADBEEF, wbAddr_o 5, wbEnable_o 1.
2. LB at 0x013 on the same word → byte_en 1000, result_o 0xFFFFFFDE; LBU at 0x013 → 0x000000DE.
3. SW 0x11223344 at 0x016 → T+1 write addr 0x014, byte_en 1100, data_o 0x33440000; T+2 write addr 0x018, byte_en 0011, data_o 0x00001122; result_valid_o at T+3.
4. LH at 0x7FF (last byte) → accesses at 0x7FC (byte_en 1000) and 0x000 (byte_en 0001), showing word-index wrap; with mem[0x7FF] = 0x80 and mem[0x000] = 0x01, result_o is 0x00000180.
5. funct3 011 → no mem_en_o; at T+1 result_valid_o = 1, err_o = 1, wbEnable_o = 0; ready_o returns the following cycle.
6. reset_i asserted during ISSUE1 of a split store, or flush_i asserted in WAIT → outputs zero or the state returns to IDLE, no result_valid_o pulse, and the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Holds the funct3 encodings, the FSM state type and the access-size decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        WAIT,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] nbytes;
    } size_info_t;

    // Unsigned variants have no store counterpart, so funct3[2] is illegal on stores.
    function automatic size_info_t size_decode(input logic [2:0] funct3, input logic is_store);
        size_info_t info;
        info.legal  = 1'b1;
        info.nbytes = 3'd1;
        case (funct3)
            F3_B, F3_BU: info.nbytes = 3'd1;
            F3_H, F3_HU: info.nbytes = 3'd2;
            F3_W:        info.nbytes = 3'd4;
            default:     info.legal  = 1'b0;
        endcase
        if (is_store && funct3[2]) begin
            info.legal = 1'b0;
        end
        return info;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: lane enables and positioned store data for
// both word accesses, plus reassembly and sign/zero extension of load data.
module lsu_lane_align (
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata0_i,
    input  logic [31:0] rdata1_i,
    input  logic        sign_ext_i,
    output logic [3:0]  lanes0_o,
    output logic [3:0]  lanes1_o,
    output logic [63:0] sdata_o,
    output logic [31:0] load_data_o
);

    logic [3:0]  size_mask;
    logic [63:0] byte_mask;
    logic [63:0] shifted;
    logic [31:0] raw;

    always_comb begin
        size_mask = 4'b0000;
        case (size_i)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase

        // Bytes shifted past lane 3 of the first word spill into the second word.
        lanes0_o = size_mask << offset_i;
        lanes1_o = size_mask >> (3'd4 - {1'b0, offset_i});

        byte_mask = '0;
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8]      = {8{lanes0_o[i]}};
            byte_mask[32 + 8*i +: 8] = {8{lanes1_o[i]}};
        end
        shifted = {32'b0, wdata_i} << {offset_i, 3'b000};
        sdata_o = shifted & byte_mask;
    end

    always_comb begin
        raw = rdata0_i;
        case (offset_i)
            2'd0: raw = rdata0_i;
            2'd1: raw = {rdata1_i[7:0],  rdata0_i[31:8]};
            2'd2: raw = {rdata1_i[15:0], rdata0_i[31:16]};
            2'd3: raw = {rdata1_i[23:0], rdata0_i[31:24]};
            default: raw = rdata0_i;
        endcase

        load_data_o = raw;
        case (size_i)
            3'd1: load_data_o = {{24{sign_ext_i & raw[7]}},  raw[7:0]};
            3'd2: load_data_o = {{16{sign_ext_i & raw[15]}}, raw[15:0]};
            default: load_data_o = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one EX load/store into one or two word-aligned
// accesses, reassembles load data and returns it with the write-back tag.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              ready_o,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        wbAddr_i,
    input  logic              wbEnable_i,
    input  logic              flush_i,
    output logic              mem_en_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        byte_en_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              err_o,
    output logic [4:0]        wbAddr_o,
    output logic              wbEnable_o
);

    localparam int WIDX_W = ADDR_W - 2;

    lsu_state_t        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic              sign_ext_q, sign_ext_d;
    logic [2:0]        size_q, size_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic              wb_en_q, wb_en_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    size_info_t        req_size;
    logic              split;
    logic [WIDX_W-1:0] word0;
    logic [WIDX_W-1:0] word1;
    logic [3:0]        lanes0;
    logic [3:0]        lanes1;
    logic [63:0]       sdata;
    logic [31:0]       load_data;

    assign req_size = size_decode(funct3_i, is_store_i);
    assign split    = ({2'b00, addr_q[1:0]} + {1'b0, size_q}) > 4'd4;
    assign word0    = addr_q[ADDR_W-1:2];
    assign word1    = word0 + 1'b1;

    lsu_lane_align u_lane_align (
        .offset_i    (addr_q[1:0]),
        .size_i      (size_q),
        .wdata_i     (wdata_q),
        .rdata0_i    (rdata0_q),
        .rdata1_i    (split ? rdata1_q : '0),
        .sign_ext_i  (sign_ext_q),
        .lanes0_o    (lanes0),
        .lanes1_o    (lanes1),
        .sdata_o     (sdata),
        .load_data_o (load_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            sign_ext_q <= 1'b0;
            size_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_addr_q  <= '0;
            wb_en_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            sign_ext_q <= sign_ext_d;
            size_q     <= size_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_addr_q  <= wb_addr_d;
            wb_en_q    <= wb_en_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        sign_ext_d = sign_ext_q;
        size_d     = size_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_addr_d  = wb_addr_q;
        wb_en_d    = wb_en_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    is_store_d = is_store_i;
                    sign_ext_d = ~funct3_i[2];
                    size_d     = req_size.nbytes;
                    err_d      = ~req_size.legal;
                    addr_d     = addr_i;
                    wdata_d    = wdata_i;
                    wb_addr_d  = wbAddr_i;
                    wb_en_d    = wbEnable_i;
                    rdata0_d   = '0;
                    rdata1_d   = '0;
                    state_d    = req_size.legal ? ISSUE0 : RESP;
                end
            end
            ISSUE0: begin
                if (split) begin
                    state_d = ISSUE1;
                end else begin
                    state_d = is_store_q ? RESP : WAIT;
                end
            end
            ISSUE1: begin
                if (!is_store_q) begin
                    rdata0_d = rdata_i;
                end
                state_d = is_store_q ? RESP : WAIT;
            end
            WAIT: begin
                if (split) begin
                    rdata1_d = rdata_i;
                end else begin
                    rdata0_d = rdata_i;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The access driven this cycle still reaches memory; only the sequence is abandoned.
        if (flush_i && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ready_o        = 1'b0;
        mem_en_o       = 1'b0;
        wr_en_o        = 1'b0;
        addr_o         = '0;
        byte_en_o      = 4'b0000;
        data_o         = '0;
        result_o       = '0;
        result_valid_o = 1'b0;
        err_o          = 1'b0;
        wbAddr_o       = '0;
        wbEnable_o     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            ISSUE0: begin
                mem_en_o  = 1'b1;
                wr_en_o   = is_store_q;
                addr_o    = {word0, 2'b00};
                byte_en_o = lanes0;
                data_o    = is_store_q ? sdata[31:0] : '0;
            end
            ISSUE1: begin
                mem_en_o  = 1'b1;
                wr_en_o   = is_store_q;
                addr_o    = {word1, 2'b00};
                byte_en_o = lanes1;
                data_o    = is_store_q ? sdata[63:32] : '0;
            end
            RESP: begin
                result_valid_o = 1'b1;
                result_o       = (is_store_q || err_q) ? '0 : load_data;
                err_o          = err_q;
                wbAddr_o       = wb_addr_q;
                wbEnable_o     = wb_en_q & ~err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit against a byte-enabled word
// memory, with hand-written sequences for reset and flush corner cases.
module tb_load_store_unit;

    localparam int ADDR_W = 11;
    localparam int NVEC   = 21;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              ready_o;
    logic              is_store_i = 1'b0;
    logic [2:0]        funct3_i = 3'b000;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic [4:0]        wbAddr_i = '0;
    logic              wbEnable_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              mem_en_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] addr_o;
    logic [3:0]        byte_en_o;
    logic [31:0]       data_o;
    logic [31:0]       rdata_i;
    logic [31:0]       result_o;
    logic              result_valid_o;
    logic              err_o;
    logic [4:0]        wbAddr_o;
    logic              wbEnable_o;

    logic [31:0] mem [0:511];
    logic        mem_clr = 1'b0;
    logic        bd_we = 1'b0;
    logic [8:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              st;
        logic [2:0]        f3;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [4:0]        tag;
        logic              wben;
        logic [31:0]       exp_res;
        logic              exp_err;
        int                exp_lat;
        int                exp_nacc;
        logic [ADDR_W-1:0] a0;
        logic [3:0]        be0;
        logic [31:0]       d0;
        logic [ADDR_W-1:0] a1;
        logic [3:0]        be1;
        logic [31:0]       d1;
    } vec_t;

    vec_t vecs [NVEC];

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .ready_o        (ready_o),
        .is_store_i     (is_store_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .wbAddr_i       (wbAddr_i),
        .wbEnable_i     (wbEnable_i),
        .flush_i        (flush_i),
        .mem_en_o       (mem_en_o),
        .wr_en_o        (wr_en_o),
        .addr_o         (addr_o),
        .byte_en_o      (byte_en_o),
        .data_o         (data_o),
        .rdata_i        (rdata_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .err_o          (err_o),
        .wbAddr_o       (wbAddr_o),
        .wbEnable_o     (wbEnable_o)
    );

    always #5 clk_i = ~clk_i;

    // Word memory with one-cycle read latency; backdoor port preloads contents.
    always @(posedge clk_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_en_o) begin
            if (wr_en_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en_o[b]) mem[addr_o[ADDR_W-1:2]][8*b +: 8] <= data_o[8*b +: 8];
                end
            end else begin
                rdata_i <= mem[addr_o[ADDR_W-1:2]];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic backdoor(input logic [8:0] idx, input logic [31:0] data);
        @(negedge clk_i);
        bd_idx = idx;
        bd_data = data;
        bd_we = 1'b1;
        @(negedge clk_i);
        bd_we = 1'b0;
    endtask

    task automatic watchNoResult(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            if (result_valid_o) seen++;
            @(negedge clk_i);
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t              v;
        int                lat;
        int                nacc;
        logic [ADDR_W-1:0] acc_a [2];
        logic [3:0]        acc_be [2];
        logic [31:0]       acc_d [2];
        logic              acc_wr [2];
        logic [31:0]       res;
        logic              err;
        logic              wben;
        logic [4:0]        wba;
        v = vecs[idx];
        lat = -1;
        nacc = 0;
        res = '0;
        err = 1'b0;
        wben = 1'b0;
        wba = '0;
        for (int i = 0; i < 2; i++) begin
            acc_a[i] = '0;
            acc_be[i] = '0;
            acc_d[i] = '0;
            acc_wr[i] = 1'b0;
        end

        @(negedge clk_i);
        checkOutput($sformatf("v%0d ready_before", idx), 32'(ready_o), 32'd1);
        is_store_i  = v.st;
        funct3_i    = v.f3;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        wbAddr_i    = v.tag;
        wbEnable_i  = v.wben;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;

        for (int k = 1; k <= 10; k++) begin
            if (mem_en_o) begin
                if (nacc < 2) begin
                    acc_a[nacc]  = addr_o;
                    acc_be[nacc] = byte_en_o;
                    acc_d[nacc]  = data_o;
                    acc_wr[nacc] = wr_en_o;
                end
                nacc++;
            end
            if (result_valid_o) begin
                lat  = k;
                res  = result_o;
                err  = err_o;
                wben = wbEnable_o;
                wba  = wbAddr_o;
                break;
            end
            @(negedge clk_i);
        end

        checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        checkOutput($sformatf("v%0d result", idx), res, v.exp_res);
        checkOutput($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        checkOutput($sformatf("v%0d wbAddr", idx), 32'(wba), 32'(v.tag));
        checkOutput($sformatf("v%0d wbEnable", idx), 32'(wben), 32'(v.wben & ~v.exp_err));
        checkOutput($sformatf("v%0d accesses", idx), 32'(nacc), 32'(v.exp_nacc));
        if (v.exp_nacc > 0) begin
            checkOutput($sformatf("v%0d addr0", idx), 32'(acc_a[0]), 32'(v.a0));
            checkOutput($sformatf("v%0d be0", idx), 32'(acc_be[0]), 32'(v.be0));
            checkOutput($sformatf("v%0d data0", idx), acc_d[0], v.d0);
            checkOutput($sformatf("v%0d wr0", idx), 32'(acc_wr[0]), 32'(v.st));
        end
        if (v.exp_nacc > 1) begin
            checkOutput($sformatf("v%0d addr1", idx), 32'(acc_a[1]), 32'(v.a1));
            checkOutput($sformatf("v%0d be1", idx), 32'(acc_be[1]), 32'(v.be1));
            checkOutput($sformatf("v%0d data1", idx), acc_d[1], v.d1);
            checkOutput($sformatf("v%0d wr1", idx), 32'(acc_wr[1]), 32'(v.st));
        end
        @(negedge clk_i);
        checkOutput($sformatf("v%0d ready_after", idx), 32'(ready_o), 32'd1);
    endtask

    initial begin
        //           st  f3      addr     wdata         tag wben result        err lat n  a0       be0      d0            a1       be1      d1
        vecs[0]  = '{0, 3'b010, 11'h010, 32'h0,        5,  1, 32'hDEADBEEF, 0,  3,  1, 11'h010, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[1]  = '{0, 3'b000, 11'h013, 32'h0,        6,  1, 32'hFFFFFFDE, 0,  3,  1, 11'h010, 4'b1000, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[2]  = '{0, 3'b100, 11'h013, 32'h0,        6,  1, 32'h000000DE, 0,  3,  1, 11'h010, 4'b1000, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[3]  = '{0, 3'b001, 11'h012, 32'h0,        8,  1, 32'hFFFFDEAD, 0,  3,  1, 11'h010, 4'b1100, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[4]  = '{0, 3'b101, 11'h011, 32'h0,        9,  1, 32'h0000ADBE, 0,  3,  1, 11'h010, 4'b0110, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[5]  = '{1, 3'b010, 11'h016, 32'h11223344, 7,  0, 32'h0,        0,  3,  2, 11'h014, 4'b1100, 32'h33440000, 11'h018, 4'b0011, 32'h00001122};
        vecs[6]  = '{0, 3'b010, 11'h014, 32'h0,        1,  1, 32'h33440000, 0,  3,  1, 11'h014, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[7]  = '{0, 3'b010, 11'h016, 32'h0,        2,  1, 32'h11223344, 0,  4,  2, 11'h014, 4'b1100, 32'h0,        11'h018, 4'b0011, 32'h0};
        vecs[8]  = '{0, 3'b001, 11'h7FF, 32'h0,        3,  1, 32'h00000180, 0,  4,  2, 11'h7FC, 4'b1000, 32'h0,        11'h000, 4'b0001, 32'h0};
        vecs[9]  = '{0, 3'b011, 11'h010, 32'h0,        9,  1, 32'h0,        1,  1,  0, 11'h0,   4'b0000, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[10] = '{1, 3'b100, 11'h020, 32'hAABBCCDD, 4,  1, 32'h0,        1,  1,  0, 11'h0,   4'b0000, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[11] = '{1, 3'b000, 11'h021, 32'hAABBCCDD, 10, 0, 32'h0,        0,  2,  1, 11'h020, 4'b0010, 32'h0000DD00, 11'h0,   4'b0000, 32'h0};
        vecs[12] = '{0, 3'b100, 11'h021, 32'h0,        12, 1, 32'h000000DD, 0,  3,  1, 11'h020, 4'b0010, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[13] = '{0, 3'b000, 11'h021, 32'h0,        13, 1, 32'hFFFFFFDD, 0,  3,  1, 11'h020, 4'b0010, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[14] = '{1, 3'b001, 11'h023, 32'hFFFF8001, 14, 0, 32'h0,        0,  3,  2, 11'h020, 4'b1000, 32'h01000000, 11'h024, 4'b0001, 32'h00000080};
        vecs[15] = '{0, 3'b010, 11'h020, 32'h0,        15, 1, 32'h0100DD00, 0,  3,  1, 11'h020, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[16] = '{0, 3'b001, 11'h023, 32'h0,        16, 1, 32'hFFFF8001, 0,  4,  2, 11'h020, 4'b1000, 32'h0,        11'h024, 4'b0001, 32'h0};
        vecs[17] = '{0, 3'b110, 11'h010, 32'h0,        17, 1, 32'h0,        1,  1,  0, 11'h0,   4'b0000, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[18] = '{0, 3'b010, 11'h02C, 32'h0,        18, 1, 32'h77880000, 0,  3,  1, 11'h02C, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[19] = '{0, 3'b010, 11'h030, 32'h0,        19, 1, 32'h0,        0,  3,  1, 11'h030, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};
        vecs[20] = '{0, 3'b010, 11'h010, 32'h0,        20, 1, 32'hDEADBEEF, 0,  3,  1, 11'h010, 4'b1111, 32'h0,        11'h0,   4'b0000, 32'h0};

        @(negedge clk_i);
        mem_clr = 1'b1;
        @(negedge clk_i);
        mem_clr = 1'b0;
        backdoor(9'd4,   32'hDEADBEEF);
        backdoor(9'd511, 32'h80000000);
        backdoor(9'd0,   32'h00000001);

        checkOutput("reset ready", 32'(ready_o), 32'd1);
        checkOutput("reset mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("reset result_valid", 32'(result_valid_o), 32'd0);
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset wbEnable", 32'(wbEnable_o), 32'd0);
        reset_i = 1'b0;

        for (int i = 0; i < 18; i++) applyStimulus(i);

        // Reset lands in ISSUE1 of a split store: second write must never happen.
        @(negedge clk_i);
        is_store_i = 1'b1;
        funct3_i = 3'b010;
        addr_i = 11'h02E;
        wdata_i = 32'h55667788;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        checkOutput("rst_seq issue0 addr", 32'(addr_o), 32'h02C);
        @(negedge clk_i);
        checkOutput("rst_seq issue1 addr", 32'(addr_o), 32'h030);
        reset_i = 1'b1;
        #1;
        checkOutput("rst_seq mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("rst_seq byte_en", 32'(byte_en_o), 32'd0);
        checkOutput("rst_seq data", data_o, 32'd0);
        checkOutput("rst_seq ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        reset_i = 1'b0;
        watchNoResult("rst_seq no_result", 4);
        applyStimulus(18);
        applyStimulus(19);

        // Flush while waiting on load data.
        @(negedge clk_i);
        is_store_i = 1'b0;
        funct3_i = 3'b010;
        addr_i = 11'h010;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("flush_wait mem_en", 32'(mem_en_o), 32'd0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flush_wait ready", 32'(ready_o), 32'd1);
        watchNoResult("flush_wait no_result", 4);

        // Flush in IDLE must block acceptance of a simultaneous request.
        flush_i = 1'b1;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        checkOutput("flush_idle ready", 32'(ready_o), 32'd1);
        checkOutput("flush_idle mem_en", 32'(mem_en_o), 32'd0);
        watchNoResult("flush_idle no_result", 4);

        applyStimulus(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
